// File: rtl/sr_pulse_gen.sv
// -----------------------------------------------------------------------------
// sr_pulse_gen
//
// Front-end conditioning for an active-high SR latch. Two raw pushbutton
// inputs are each synchronized, debounced and edge-detected. A press sets a
// pending request for that channel. A small FSM turns the pending requests
// into clean, registered, fixed-width pulses on s / r. The two outputs are
// never high in the same cycle. A reset request wins over a set request.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed before a
//                     level change is accepted (>= 1)
//   PULSE_WIDTH     : number of cycles each s / r pulse stays high (>= 1)
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   set_btn   in   raw set button (asynchronous, may bounce)
//   reset_btn in   raw reset button (asynchronous, may bounce)
//   s         out  registered set pulse to the latch
//   r         out  registered reset pulse to the latch
//   busy      out  registered, high while a pulse or its trailing gap runs
// -----------------------------------------------------------------------------
module sr_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW_W = $clog2(PULSE_WIDTH + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_WIDTH - 1);

    // Channel index 0 is the set button and channel index 1 is the reset button.
    localparam int CH_SET = 0;
    localparam int CH_RST = 1;

    logic [1:0] raw_btn;
    logic [1:0] rise;      // one-cycle press strobe per channel
    logic [1:0] req;       // pending request per channel
    logic [1:0] take;      // FSM consumes the request this cycle

    assign raw_btn = {reset_btn, set_btn};

    // -------------------------------------------------------------------------
    // Per-channel synchronizer, debouncer, edge detector and pending flag
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic            db_prev_reg;
            logic [DB_W-1:0] cnt_reg;
            logic            req_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= raw_btn[gi];
                    sync2_reg   <= sync1_reg;
                    db_prev_reg <= db_reg;
                    // Any sample that agrees with the accepted level restarts
                    // the run, so only an unbroken run of DEBOUNCE_CYCLES
                    // differing samples can flip db.
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            // Only the press (rising) edge matters. A release does nothing.
            assign rise[gi] = db_reg & ~db_prev_reg;

            // A new edge wins over a same-cycle consume, so a press that lands
            // on the edge where the FSM takes the old request is kept for the
            // next pulse. Repeated presses while pending merge into one request.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_reg <= 1'b0;
                end else begin
                    req_reg <= (req_reg & ~take[gi]) | rise[gi];
                end
            end

            assign req[gi] = req_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pulse FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PW_W-1:0] pcnt_reg;
    logic [PW_W-1:0] pcnt_next;
    logic            s_reg;
    logic            r_reg;
    logic            busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pcnt_reg  <= pcnt_next;
        end
    end

    // GAP already holds both outputs low, so it can dispatch a pending
    // request the same way IDLE does. That gives the pulse-to-pulse spacing
    // of PULSE_WIDTH+1 cycles when both requests are queued.
    always_comb begin
        state_next = state_reg;
        pcnt_next  = pcnt_reg;
        take       = 2'b00;
        unique case (state_reg)
            IDLE, GAP: begin
                pcnt_next = '0;
                if (req[CH_RST]) begin
                    state_next   = PULSE_R;
                    take[CH_RST] = 1'b1;
                end else if (req[CH_SET]) begin
                    state_next   = PULSE_S;
                    take[CH_SET] = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            PULSE_S, PULSE_R: begin
                if (pcnt_reg == PW_LAST) begin
                    state_next = GAP;
                    pcnt_next  = '0;
                end else begin
                    pcnt_next = pcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                pcnt_next  = '0;
            end
        endcase
    end

    // The outputs are registered from the next state. This keeps them aligned
    // with state_reg and free of glitches. Only one state can drive a pulse,
    // so s and r can never be high together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg    <= 1'b0;
            r_reg    <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            s_reg    <= (state_next == PULSE_S);
            r_reg    <= (state_next == PULSE_R);
            busy_reg <= (state_next != IDLE);
        end
    end

    assign s    = s_reg;
    assign r    = r_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_sr_pulse_gen
//
// Directed testbench for sr_pulse_gen at the default parameters
// (DEBOUNCE_CYCLES=4, PULSE_WIDTH=2). Inputs change 1 ns after a rising edge.
// Outputs are sampled 1 ns after each rising edge. In every loop, tick i puts
// the bench just after edge k+i-1, where edge k is the first edge that samples
// the new input. A pulse expected "after edge k+7" is therefore seen at i=8.
// -----------------------------------------------------------------------------
module tb_sr_pulse_gen;

    logic clk;
    logic rst_n;
    logic set_btn;
    logic reset_btn;
    logic s;
    logic r;
    logic busy;

    int total;
    int bad;

    sr_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_WIDTH    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_btn  (set_btn),
        .reset_btn(reset_btn),
        .s        (s),
        .r        (r),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both buttons are held low. The bench lets any release settle and
    // checks that no output moves.
    task automatic test_quiet(input string name, input int n);
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        for (int i = 1; i <= n; i++) begin
            tick();
            total++;
            if ({s, r, busy} !== 3'b000) begin
                bad++;
                $display("FAIL %s tick %0d: {s,r,busy} got %b want 000", name, i, {s, r, busy});
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            set_btn   = ~set_btn;
            reset_btn = (i % 3) == 0;
            tick();
            total++;
            if ({s, r, busy} !== 3'b000) begin
                bad++;
                $display("FAIL reset tick %0d: {s,r,busy} got %b want 000", i, {s, r, busy});
            end
        end
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        tick();
        rst_n = 1'b1;
        test_quiet("post_reset", 4);
    endtask

    task automatic test_single_set();
        logic [2:0] exp;
        set_btn = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp = {(i == 8 || i == 9), 1'b0, (i >= 8 && i <= 10)};
            total++;
            if ({s, r, busy} !== exp) begin
                bad++;
                $display("FAIL single_set tick %0d: {s,r,busy} got %b want %b", i, {s, r, busy}, exp);
            end
        end
        test_quiet("single_set_release", 14);
    endtask

    task automatic test_bounce();
        for (int i = 1; i <= 24; i++) begin
            if ((i % 2) == 1) set_btn = ~set_btn;
            tick();
            total++;
            if ({s, r, busy} !== 3'b000) begin
                bad++;
                $display("FAIL bounce tick %0d: {s,r,busy} got %b want 000", i, {s, r, busy});
            end
        end
        test_quiet("bounce_tail", 12);
    endtask

    // A raw high of 3 cycles is one sample short of acceptance and must be
    // ignored. A raw high of exactly 4 cycles must be accepted and give one pulse.
    task automatic test_glitch_boundary();
        logic [2:0] exp;
        set_btn = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 4) set_btn = 1'b0;
            tick();
            total++;
            if ({s, r, busy} !== 3'b000) begin
                bad++;
                $display("FAIL glitch3 tick %0d: {s,r,busy} got %b want 000", i, {s, r, busy});
            end
        end
        set_btn = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) set_btn = 1'b0;
            tick();
            exp = {(i == 8 || i == 9), 1'b0, (i >= 8 && i <= 10)};
            total++;
            if ({s, r, busy} !== exp) begin
                bad++;
                $display("FAIL glitch4 tick %0d: {s,r,busy} got %b want %b", i, {s, r, busy}, exp);
            end
        end
        test_quiet("glitch_tail", 8);
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp;
        set_btn   = 1'b1;
        reset_btn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp = {(i == 11 || i == 12), (i == 8 || i == 9), (i >= 8 && i <= 13)};
            total++;
            if ({s, r, busy} !== exp) begin
                bad++;
                $display("FAIL simultaneous tick %0d: {s,r,busy} got %b want %b", i, {s, r, busy}, exp);
            end
            total++;
            if ((s & r) !== 1'b0) begin
                bad++;
                $display("FAIL s_and_r tick %0d: s&r got %b want 0", i, s & r);
            end
        end
        test_quiet("simultaneous_release", 14);
    endtask

    task automatic test_reset_mid_pulse();
        logic [2:0] exp;
        set_btn = 1'b1;
        for (int i = 1; i <= 8; i++) tick();
        total++;
        if ({s, r, busy} !== 3'b101) begin
            bad++;
            $display("FAIL mid_pulse_pre: {s,r,busy} got %b want 101", {s, r, busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({s, r, busy} !== 3'b000) begin
            bad++;
            $display("FAIL mid_pulse_async: {s,r,busy} got %b want 000", {s, r, busy});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp = {(i == 8 || i == 9), 1'b0, (i >= 8 && i <= 10)};
            total++;
            if ({s, r, busy} !== exp) begin
                bad++;
                $display("FAIL mid_pulse_rearm tick %0d: {s,r,busy} got %b want %b", i, {s, r, busy}, exp);
            end
        end
        test_quiet("mid_pulse_release", 14);
    endtask

    task automatic test_request_during_pulse();
        logic [2:0] exp;
        set_btn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 2) reset_btn = 1'b1;
            exp = {(i == 8 || i == 9), (i == 11 || i == 12), (i >= 8 && i <= 13)};
            total++;
            if ({s, r, busy} !== exp) begin
                bad++;
                $display("FAIL during_pulse tick %0d: {s,r,busy} got %b want %b", i, {s, r, busy}, exp);
            end
        end
        test_quiet("during_pulse_release", 14);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        #1;
        test_reset();
        test_single_set();
        test_bounce();
        test_glitch_boundary();
        test_simultaneous();
        test_reset_mid_pulse();
        test_request_during_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
